// File: rtl/regularized_trig_unit_if.sv
// regularized_trig_unit_if: condition and angle bus for regularized_trig_unit
interface regularized_trig_unit_if #(parameter int N = 4);
   logic [N-1:0]       i_signal, o_signal;
   logic signed [31:0] i_theta, o_sin, o_cos;
   modport master (output i_signal, i_theta, input o_signal, o_sin, o_cos);
   modport slave (input i_signal, i_theta, output o_signal, o_sin, o_cos);
endinterface

// File: rtl/regularized_trig_unit.sv
// regularized_trig_unit: debounced, dwell-limited jump conditions plus integer-degree sin/cos
module regularized_trig_unit #(
   parameter int DEBOUNCE_TIME = 2,
   parameter int DELAY = 20,
   parameter int N = 4
) (
   input logic                    i_clk,
   input logic                    i_reset,
   regularized_trig_unit_if.slave bus
);
   localparam int DB = DEBOUNCE_TIME < 1 ? 1 : DEBOUNCE_TIME;
   localparam int DW = $clog2(DB + 1);
   localparam int LW = DELAY < 1 ? 1 : $clog2(DELAY + 1);
   for (genvar k = 0; k < N; k++) begin : g_bit
      logic          out_q;
      logic [DW-1:0] db_q;
      logic [LW-1:0] lock_q;
      assign bus.o_signal[k] = out_q;
      // the edge that would bring the count to DB commits the change and starts the dwell lockout
      always_ff @(posedge i_clk or posedge i_reset)
         if (i_reset) begin
            out_q  <= 1'b0;
            db_q   <= '0;
            lock_q <= '0;
         end else if (lock_q != '0) begin
            db_q   <= '0;
            lock_q <= lock_q - 1'b1;
         end else if (bus.i_signal[k] == out_q)
            db_q <= '0;
         else if (db_q == DW'(DB - 1)) begin
            out_q  <= bus.i_signal[k];
            db_q   <= '0;
            lock_q <= LW'(DELAY);
         end else
            db_q <= db_q + 1'b1;
   end
   localparam logic [9:0] Q [0:90] = '{
      10'd0,   10'd17,  10'd35,  10'd52,  10'd70,  10'd87,  10'd105, 10'd122, 10'd139, 10'd156,
      10'd174, 10'd191, 10'd208, 10'd225, 10'd242, 10'd259, 10'd276, 10'd292, 10'd309, 10'd326,
      10'd342, 10'd358, 10'd375, 10'd391, 10'd407, 10'd423, 10'd438, 10'd454, 10'd469, 10'd485,
      10'd500, 10'd515, 10'd530, 10'd545, 10'd559, 10'd574, 10'd588, 10'd602, 10'd616, 10'd629,
      10'd643, 10'd656, 10'd669, 10'd682, 10'd695, 10'd707, 10'd719, 10'd731, 10'd743, 10'd755,
      10'd766, 10'd777, 10'd788, 10'd799, 10'd809, 10'd819, 10'd829, 10'd839, 10'd848, 10'd857,
      10'd866, 10'd875, 10'd883, 10'd891, 10'd899, 10'd906, 10'd914, 10'd921, 10'd927, 10'd934,
      10'd940, 10'd946, 10'd951, 10'd956, 10'd961, 10'd966, 10'd970, 10'd974, 10'd978, 10'd982,
      10'd985, 10'd988, 10'd990, 10'd993, 10'd995, 10'd996, 10'd998, 10'd999, 10'd999, 10'd1000,
      10'd1000
   };
   function automatic logic signed [31:0] sin_deg(input logic [8:0] a);
      logic [8:0]         i;
      logic signed [31:0] m;
      i = a <= 9'd90 ? a : a <= 9'd180 ? 9'd180 - a : a <= 9'd270 ? a - 9'd180 : 9'd360 - a;
      m = $signed({22'd0, Q[i[6:0]]});
      sin_deg = a > 9'd180 ? -m : m;
   endfunction
   logic signed [31:0] rem;
   logic [8:0]         ang, ang_c;
   // truncating % keeps the dividend's sign, so fold negatives back into [0,359]
   always_comb begin
      rem   = bus.i_theta % 32'sd360;
      ang   = 9'(rem < 0 ? rem + 32'sd360 : rem);
      ang_c = ang >= 9'd270 ? ang - 9'd270 : ang + 9'd90;
   end
   assign bus.o_sin = sin_deg(ang);
   assign bus.o_cos = sin_deg(ang_c);
endmodule

// File: tb/tb_regularized_trig_unit.sv
// tb_regularized_trig_unit: vector table, hand sequences and random run against a behavioural model
module tb_regularized_trig_unit;
   localparam int N = 4, D = 2, DL = 20;
   localparam real PI = 3.14159265358979323846;
   logic i_clk = 1'b0, i_reset = 1'b1;
   regularized_trig_unit_if #(.N(N)) bus ();
   regularized_trig_unit #(.DEBOUNCE_TIME(D), .DELAY(DL), .N(N)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .bus(bus));
   always #5 i_clk = ~i_clk;
   int total = 0, bad = 0;
   logic [N-1:0] m_out;
   int m_run [N];
   int m_last [N];
   int edge_n = 0;
   typedef struct {logic signed [31:0] th; int s; int c;} trig_v_t;
   trig_v_t tv [11];
   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask
   function automatic int ref_trig(input longint t, input bit c);
      longint a;
      real x;
      a = ((t % 360) + 360) % 360;
      x = 1000.0 * (c ? $cos(a * PI / 180.0) : $sin(a * PI / 180.0));
      return x >= 0.0 ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
   endfunction
   task automatic model_reset();
      m_out = '0;
      for (int k = 0; k < N; k++) begin
         m_run[k]  = 0;
         m_last[k] = -1000000;
      end
   endtask
   // a change is allowed once DL edges have passed since the last one and D eligible mismatching edges accrue
   task automatic model_edge();
      edge_n++;
      for (int k = 0; k < N; k++)
         if (edge_n <= m_last[k] + DL) m_run[k] = 0;
         else if (bus.i_signal[k] != m_out[k]) begin
            m_run[k]++;
            if (m_run[k] >= D) begin
               m_out[k]  = bus.i_signal[k];
               m_run[k]  = 0;
               m_last[k] = edge_n;
            end
         end else m_run[k] = 0;
   endtask
   task automatic tick();
      @(posedge i_clk);
      if (!i_reset) model_edge();
      @(negedge i_clk);
      chk("o_signal_model", longint'(bus.o_signal), longint'(m_out));
   endtask
   task automatic do_reset();
      @(negedge i_clk);
      i_reset = 1'b1;
      model_reset();
      #1 chk("reset_async", longint'(bus.o_signal), 0);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask
   task automatic chk_trig(input string nm, input logic signed [31:0] th, input int s, input int c);
      bus.i_theta = th;
      #1;
      chk({nm, "_sin"}, longint'(bus.o_sin), s);
      chk({nm, "_cos"}, longint'(bus.o_cos), c);
   endtask
   initial begin
      tv[0]  = '{32'sd0, 0, 1000};
      tv[1]  = '{32'sd30, 500, 866};
      tv[2]  = '{32'sd45, 707, 707};
      tv[3]  = '{32'sd90, 1000, 0};
      tv[4]  = '{32'sd180, 0, -1000};
      tv[5]  = '{32'sd270, -1000, 0};
      tv[6]  = '{-32'sd30, -500, 866};
      tv[7]  = '{32'sd390, 500, 866};
      tv[8]  = '{-32'sd450, -1000, 0};
      tv[9]  = '{32'sh80000000, -788, -616};
      tv[10] = '{32'sd232, -788, -616};
      bus.i_signal = '0;
      bus.i_theta  = '0;
      model_reset();
      repeat (2) @(negedge i_clk);
      chk("reset_state", longint'(bus.o_signal), 0);
      i_reset = 1'b0;
      for (int i = 0; i < 11; i++) chk_trig($sformatf("trig_tab%0d", i), tv[i].th, tv[i].s, tv[i].c);
      // reset during lockout, then power-up behaviour with input held high
      bus.i_signal = 4'hF;
      tick();
      chk("deb_edge1", longint'(bus.o_signal), 0);
      tick();
      chk("deb_edge2", longint'(bus.o_signal), 4'hF);
      @(negedge i_clk);
      i_reset = 1'b1;
      model_reset();
      #1 chk("reset_mid_lockout", longint'(bus.o_signal), 0);
      @(posedge i_clk);
      #1 chk("reset_hold", longint'(bus.o_signal), 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      tick();
      chk("rel_edge1", longint'(bus.o_signal), 0);
      tick();
      chk("rel_edge2", longint'(bus.o_signal), 4'hF);
      // single-cycle glitch on bit0
      bus.i_signal = 4'h0;
      do_reset();
      bus.i_signal = 4'h1;
      tick();
      bus.i_signal = 4'h0;
      for (int e = 0; e < 4; e++) begin
         tick();
         chk("glitch_b0", longint'(bus.o_signal[0]), 0);
      end
      // bit1 lockout with an in-lockout toggle
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         bus.i_signal = (e <= 2 || e == 6) ? 4'h2 : 4'h0;
         tick();
         chk($sformatf("lockout_b1_e%0d", e), longint'(bus.o_signal[1]), longint'(e >= 2 && e < 24));
      end
      // bit2 rises while bit3 is locked out
      bus.i_signal = 4'h0;
      do_reset();
      bus.i_signal = 4'h8;
      tick();
      tick();
      chk("indep_b3", longint'(bus.o_signal), 4'h8);
      bus.i_signal = 4'hC;
      tick();
      chk("indep_e1", longint'(bus.o_signal), 4'h8);
      tick();
      chk("indep_e2", longint'(bus.o_signal), 4'hC);
      // random conditions and angles
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         if ($urandom_range(0, 3) == 0) bus.i_signal = bus.i_signal ^ N'(1 << $urandom_range(0, N - 1));
         bus.i_theta = ($urandom_range(0, 1) == 0) ? $signed($urandom) : $signed(32'($urandom_range(0, 1440)) - 32'sd720);
         #1;
         chk("rnd_sin", longint'(bus.o_sin), ref_trig(longint'(bus.i_theta), 1'b0));
         chk("rnd_cos", longint'(bus.o_cos), ref_trig(longint'(bus.i_theta), 1'b1));
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
